ciphertext_uart_tx: RTL

//   Downstream stage of the Vernam cipher datapath. It takes ciphertext bytes

---
 rtl/ciphertext_uart_tx.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ciphertext_uart_tx.sv
// Ciphertext UART transmitter: buffers PicoBlaze output-port bytes in a FIFO
// and sends them as 8N1 frames, exposing {overflow, full, empty} as a status port.
module ciphertext_uart_tx #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BIT     = 3,
   parameter int STAT_BIT     = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] port_id,
   input  logic       write_strobe,
   input  logic [7:0] out_port,
   input  logic       read_strobe,
   output logic [7:0] status,
   output logic       tx,
   output logic       busy
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]        fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;

   logic push, push_ok, pop, stat_rd, empty, full, baud_done;
   logic unused_port_bits;

   assign unused_port_bits = ^port_id;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign push      = write_strobe & port_id[DATA_BIT];
   assign push_ok   = push & ~full;
   assign stat_rd   = read_strobe & port_id[STAT_BIT];
   assign baud_done = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   assign status = {5'b0, overflow_q, full, empty};
   assign tx     = tx_q;
   assign busy   = busy_q;

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      pop        = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      // tx and busy are computed one edge ahead so both leave the flops glitch-free
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_mem[rd_ptr_q];
               state_d = START;
               baud_d  = '0;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (baud_done) begin
               baud_d    = '0;
               bit_idx_d = '0;
               state_d   = DATA;
               tx_d      = shift_q[0];
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_mem[rd_ptr_q];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // a dropped byte outranks a same-cycle status read
      if (stat_rd)     overflow_d = 1'b0;
      if (push & full) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= out_port;
   end

endmodule
